// File: rtl/life_pkg.sv
// Shared types, rule masks and the birth/survive rule for the Game-of-Life row engine.
package life_pkg;

    typedef logic [3:0] nbr_cnt_t;

    localparam logic [8:0] B3_MASK  = 9'b0_0000_1000;
    localparam logic [8:0] S23_MASK = 9'b0_0000_1100;
    localparam logic [8:0] B36_MASK = 9'b0_0100_1000;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Bit n of the mask selects the outcome for a cell with n live neighbours.
    function automatic logic apply_rule(input logic cur, input nbr_cnt_t n,
                                        input logic [8:0] birth, input logic [8:0] survive);
        return cur ? survive[n] : birth[n];
    endfunction

endpackage

// File: rtl/life_row_update.sv
// Combinational next-generation computation for one row from its above/current/below rows.
module life_row_update
    import life_pkg::*;
#(
    parameter int         WIDTH        = 64,
    parameter logic [8:0] BIRTH_MASK   = B3_MASK,
    parameter logic [8:0] SURVIVE_MASK = S23_MASK
) (
    input  logic [WIDTH-1:0] i_above,
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_below,
    input  logic             i_wrap,
    output logic [WIDTH-1:0] o_next
);

    // Rows padded with column -1 at bit 0 and column WIDTH at the top bit.
    logic [WIDTH+1:0] w_above_ext;
    logic [WIDTH+1:0] w_cur_ext;
    logic [WIDTH+1:0] w_below_ext;

    assign w_above_ext = {i_wrap & i_above[0], i_above, i_wrap & i_above[WIDTH-1]};
    assign w_cur_ext   = {i_wrap & i_cur[0],   i_cur,   i_wrap & i_cur[WIDTH-1]};
    assign w_below_ext = {i_wrap & i_below[0], i_below, i_wrap & i_below[WIDTH-1]};

    for (genvar x = 0; x < WIDTH; x++) begin : g_col
        nbr_cnt_t w_n;

        assign w_n = {3'b000, w_above_ext[x]} + {3'b000, w_above_ext[x+1]} + {3'b000, w_above_ext[x+2]}
                   + {3'b000, w_cur_ext[x]}                                 + {3'b000, w_cur_ext[x+2]}
                   + {3'b000, w_below_ext[x]} + {3'b000, w_below_ext[x+1]} + {3'b000, w_below_ext[x+2]};

        assign o_next[x] = apply_rule(w_cur_ext[x+1], w_n, BIRTH_MASK, SURVIVE_MASK);
    end

endmodule

// File: rtl/life_row_engine.sv
// Game-of-Life engine updating one grid row in place per clock; define LIFE_TORUS_EN for toroidal wrap.
module life_row_engine
    import life_pkg::*;
#(
    parameter int         WIDTH        = 64,
    parameter int         HEIGHT       = 64,
    parameter logic [8:0] BIRTH_MASK   = B3_MASK,
    parameter logic [8:0] SURVIVE_MASK = S23_MASK,
    parameter int         GEN_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic [GEN_W-1:0]          i_num_gens,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [GEN_W-1:0]          o_gen_count,
    input  logic                      i_wr_en,
    input  logic [$clog2(HEIGHT)-1:0] i_wr_row,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic [$clog2(HEIGHT)-1:0] i_rd_row,
    output logic [WIDTH-1:0]          o_rd_data
);

    localparam int               ROW_W    = $clog2(HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_grid [HEIGHT];
    logic [ROW_W-1:0] r_row;
    logic [GEN_W-1:0] r_num_gens;
    logic [GEN_W-1:0] r_gen_count;
    logic [WIDTH-1:0] r_prev_orig;
    logic [WIDTH-1:0] r_rd_data;

    logic [WIDTH-1:0] w_above;
    logic [WIDTH-1:0] w_below;
    logic [WIDTH-1:0] w_next_row;
    logic             w_wrap;
    logic             w_last_row;
    logic             w_last_gen;

    assign w_last_row = (r_row == LAST_ROW);
    assign w_last_gen = ((r_gen_count + 1'b1) == r_num_gens);

`ifdef LIFE_TORUS_EN
    logic [WIDTH-1:0] r_row0_orig;

    // Row 0 is captured while it is still unmodified, for use as the wrap below the last row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row0_orig <= '0;
        end else if (r_state == RUN && r_row == '0) begin
            r_row0_orig <= r_grid[0];
        end
    end

    assign w_wrap  = 1'b1;
    assign w_above = (r_row == '0) ? r_grid[LAST_ROW] : r_prev_orig;
    assign w_below = w_last_row ? r_row0_orig : r_grid[r_row + 1'b1];
`else
    assign w_wrap  = 1'b0;
    assign w_above = (r_row == '0) ? '0 : r_prev_orig;
    assign w_below = w_last_row ? '0 : r_grid[r_row + 1'b1];
`endif

    life_row_update #(
        .WIDTH        (WIDTH),
        .BIRTH_MASK   (BIRTH_MASK),
        .SURVIVE_MASK (SURVIVE_MASK)
    ) u_row_update (
        .i_above (w_above),
        .i_cur   (r_grid[r_row]),
        .i_below (w_below),
        .i_wrap  (w_wrap),
        .o_next  (w_next_row)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = (i_num_gens == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (w_last_row && w_last_gen) begin
                    w_state_next = FIN;
                end
            end
            FIN: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_num_gens  <= '0;
            r_gen_count <= '0;
            r_prev_orig <= '0;
            r_rd_data   <= '0;
            // NOTE: the grid is a register array, so it can and must be cleared by reset.
            for (int i = 0; i < HEIGHT; i++) begin
                r_grid[i] <= '0;
            end
        end else begin
            r_state   <= w_state_next;
            r_rd_data <= r_grid[i_rd_row];
            case (r_state)
                IDLE: begin
                    if (i_wr_en) begin
                        r_grid[i_wr_row] <= i_wr_data;
                    end
                    if (i_start) begin
                        r_num_gens  <= i_num_gens;
                        r_gen_count <= '0;
                        r_row       <= '0;
                    end
                end
                RUN: begin
                    r_grid[r_row] <= w_next_row;
                    r_prev_orig   <= r_grid[r_row];
                    if (w_last_row) begin
                        r_row       <= '0;
                        r_gen_count <= r_gen_count + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_gen_count = r_gen_count;
    assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_life_row_engine.sv
// Directed self-checking bench for life_row_engine (default B3/S23 instance plus a HighLife B36 instance).
module tb_life_row_engine;

    localparam int W     = 32;
    localparam int H     = 32;
    localparam int GW    = 16;
    localparam int RW    = 5;
    localparam int LIMIT = 5000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [GW-1:0] num_gens;
    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [W-1:0]  wr_data;
    logic [RW-1:0] rd_row;
    logic          busy, done;
    logic [GW-1:0] gen_count;
    logic [W-1:0]  rd_data;
    logic          hl_busy, hl_done;
    logic [GW-1:0] hl_gen_count;
    logic [W-1:0]  hl_rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cycles;
    bit hl_done_seen;

    logic [W-1:0] pat    [H];
    logic [W-1:0] got    [H];
    logic [W-1:0] hl_got [H];
    logic [W-1:0] model  [H];
    logic [W-1:0] tmp    [H];

    always #5 clk = ~clk;

    life_row_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_num_gens(num_gens),
        .o_busy(busy), .o_done(done), .o_gen_count(gen_count),
        .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_data(wr_data),
        .i_rd_row(rd_row), .o_rd_data(rd_data)
    );

    life_row_engine #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW), .BIRTH_MASK(life_pkg::B36_MASK)) dut_hl (
        .clk(clk), .reset(reset), .i_start(start), .i_num_gens(num_gens),
        .o_busy(hl_busy), .o_done(hl_done), .o_gen_count(hl_gen_count),
        .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_data(wr_data),
        .i_rd_row(rd_row), .o_rd_data(hl_rd_data)
    );

    task automatic clear_pat();
        for (int i = 0; i < H; i++) pat[i] = '0;
    endtask

    task automatic load_pat();
        for (int i = 0; i < H; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_row  = RW'(i);
            wr_data = pat[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_grid();
        for (int i = 0; i < H; i++) begin
            @(negedge clk);
            rd_row = RW'(i);
            @(negedge clk);
            got[i]    = rd_data;
            hl_got[i] = hl_rd_data;
        end
    endtask

    // Starts a run and counts cycles from start acceptance to the done cycle.
    task automatic run_gens(input int n, input bit disturb);
        int c;
        @(negedge clk);
        start    = 1'b1;
        num_gens = GW'(n);
        @(posedge clk);
        #1;
        start        = 1'b0;
        num_gens     = '0;
        hl_done_seen = 1'b0;
        for (c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            if (c == 1 && n > 0) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_after_start: got %b want 1", busy);
                end
            end
            if (done === 1'b1) begin
                hl_done_seen = hl_done;
                break;
            end
            if (disturb && c == 10) begin
                start = 1'b1; num_gens = GW'(3); wr_en = 1'b1; wr_row = RW'(5); wr_data = '1;
            end
            if (disturb && c == 11) begin
                start = 1'b0; num_gens = '0; wr_en = 1'b0;
            end
        end
        cycles = c;
        n_cmp++;
        if (c > LIMIT) begin
            n_bad++;
            $display("FAIL run_timeout: no done within %0d cycles (num_gens=%0d)", LIMIT, n);
        end else begin
            @(negedge clk);
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL done_pulse_width: done still %b one cycle later, want 0", done);
            end
        end
    endtask

    // Reference B3/S23 step on a double-buffered whole grid.
    task automatic model_step();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
`ifdef LIFE_TORUS_EN
                        rr = (rr + H) % H;
                        cc = (cc + W) % W;
`else
                        if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
`endif
                        if (model[rr][cc]) n++;
                    end
                end
                tmp[r][c] = model[r][c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        for (int r = 0; r < H; r++) model[r] = tmp[r];
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_gens = '0; wr_en = 1'b0;
        wr_row = '0; wr_data = '0; rd_row = '0;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (gen_count !== '0) begin n_bad++; $display("FAIL reset_gen_count: got %0d want 0", gen_count); end
        if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        reset = 1'b0;
        read_grid();
        for (int i = 0; i < H; i++) begin
            n_cmp++;
            if (got[i] !== '0) begin n_bad++; $display("FAIL reset_grid row %0d: got %h want 0", i, got[i]); end
        end
    endtask

    task automatic test_blinker();
        clear_pat();
        pat[5] = 32'h0000_0070;
        load_pat();
        run_gens(1, 1'b0);
        read_grid();
        for (int i = 0; i < H; i++) begin
            logic [W-1:0] exp_row;
            exp_row = (i >= 4 && i <= 6) ? 32'h0000_0020 : 32'h0;
            n_cmp++;
            if (got[i] !== exp_row) begin n_bad++; $display("FAIL blinker_g1 row %0d: got %h want %h", i, got[i], exp_row); end
        end
        load_pat();
        run_gens(2, 1'b0);
        n_cmp++;
        if (gen_count !== GW'(2)) begin n_bad++; $display("FAIL blinker_gen_count: got %0d want 2", gen_count); end
        read_grid();
        for (int i = 0; i < H; i++) begin
            n_cmp++;
            if (got[i] !== pat[i]) begin n_bad++; $display("FAIL blinker_g2 row %0d: got %h want %h", i, got[i], pat[i]); end
        end
    endtask

    task automatic test_block();
        clear_pat();
        pat[10] = 32'h0000_0C00;
        pat[11] = 32'h0000_0C00;
        load_pat();
        run_gens(7, 1'b0);
        n_cmp += 2;
        if (cycles !== 7 * H + 1) begin n_bad++; $display("FAIL block_latency: got %0d want %0d", cycles, 7 * H + 1); end
        if (gen_count !== GW'(7)) begin n_bad++; $display("FAIL block_gen_count: got %0d want 7", gen_count); end
        read_grid();
        for (int i = 0; i < H; i++) begin
            n_cmp++;
            if (got[i] !== pat[i]) begin n_bad++; $display("FAIL block_grid row %0d: got %h want %h", i, got[i], pat[i]); end
        end
    endtask

    task automatic test_protocol();
        clear_pat();
        pat[5] = 32'h0000_0070;
        load_pat();
        run_gens(0, 1'b0);
        n_cmp += 2;
        if (cycles !== 1) begin n_bad++; $display("FAIL zero_gens_latency: got %0d want 1", cycles); end
        if (gen_count !== '0) begin n_bad++; $display("FAIL zero_gens_count: got %0d want 0", gen_count); end
        read_grid();
        for (int i = 0; i < H; i++) begin
            n_cmp++;
            if (got[i] !== pat[i]) begin n_bad++; $display("FAIL zero_gens_grid row %0d: got %h want %h", i, got[i], pat[i]); end
        end
        run_gens(1, 1'b1);
        n_cmp += 2;
        if (cycles !== H + 1) begin n_bad++; $display("FAIL ignored_inputs_latency: got %0d want %0d", cycles, H + 1); end
        if (gen_count !== GW'(1)) begin n_bad++; $display("FAIL ignored_inputs_count: got %0d want 1", gen_count); end
        read_grid();
        for (int i = 0; i < H; i++) begin
            logic [W-1:0] exp_row;
            exp_row = (i >= 4 && i <= 6) ? 32'h0000_0020 : 32'h0;
            n_cmp++;
            if (got[i] !== exp_row) begin n_bad++; $display("FAIL ignored_inputs_grid row %0d: got %h want %h", i, got[i], exp_row); end
        end
        @(negedge clk);
        wr_en = 1'b1; wr_row = RW'(7); wr_data = 32'hDEAD_BEEF; rd_row = RW'(7);
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++;
        if (rd_data !== 32'h0) begin n_bad++; $display("FAIL rd_wr_collision: got %h want 00000000", rd_data); end
        @(negedge clk);
        n_cmp++;
        if (rd_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_after_wr: got %h want deadbeef", rd_data); end
    endtask

    task automatic test_reset_midrun();
        bit done_seen;
        clear_pat();
        pat[5] = 32'h0000_0070;
        load_pat();
        @(negedge clk);
        start = 1'b1; num_gens = GW'(5);
        @(posedge clk);
        #1;
        start = 1'b0; num_gens = '0;
        repeat (3 * H + 20) @(posedge clk);
        #1;
        n_cmp += 2;
        if (gen_count !== GW'(3)) begin n_bad++; $display("FAIL midrun_gen_count: got %0d want 3", gen_count); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (gen_count !== '0) begin n_bad++; $display("FAIL abort_gen_count: got %0d want 0", gen_count); end
        done_seen = 1'b0;
        repeat (3) begin @(negedge clk); if (done) done_seen = 1'b1; end
        reset = 1'b0;
        repeat (5) begin @(negedge clk); if (done) done_seen = 1'b1; end
        n_cmp++;
        if (done_seen !== 1'b0) begin n_bad++; $display("FAIL abort_done: done pulsed after reset, want none"); end
        read_grid();
        for (int i = 0; i < H; i++) begin
            n_cmp++;
            if (got[i] !== '0) begin n_bad++; $display("FAIL abort_grid row %0d: got %h want 0", i, got[i]); end
        end
    endtask

    task automatic test_glider();
        clear_pat();
        pat[2] = 32'h0020_0000;
        pat[3] = 32'h0040_0000;
        pat[4] = 32'h0070_0000;
        load_pat();
        run_gens(4 * W, 1'b0);
        read_grid();
`ifdef LIFE_TORUS_EN
        for (int i = 0; i < H; i++) begin
            n_cmp++;
            if (got[i] !== pat[i]) begin n_bad++; $display("FAIL glider_torus row %0d: got %h want %h", i, got[i], pat[i]); end
        end
`else
        for (int i = 0; i < H; i++) model[i] = pat[i];
        for (int g = 0; g < 4 * W; g++) model_step();
        for (int i = 0; i < H; i++) begin
            n_cmp += 2;
            if (got[i] !== model[i]) begin n_bad++; $display("FAIL glider_border row %0d: got %h want %h", i, got[i], model[i]); end
            if (got[i][0] !== 1'b0) begin n_bad++; $display("FAIL glider_no_wrap row %0d: col0 got %b want 0", i, got[i][0]); end
        end
`endif
    endtask

    task automatic test_rule();
        clear_pat();
        pat[14] = 32'h0001_C000;
        pat[16] = 32'h0001_C000;
        load_pat();
        run_gens(1, 1'b0);
        n_cmp += 2;
        if (hl_done_seen !== 1'b1) begin n_bad++; $display("FAIL highlife_done: got %b want 1", hl_done_seen); end
        if (hl_gen_count !== GW'(1)) begin n_bad++; $display("FAIL highlife_gen_count: got %0d want 1", hl_gen_count); end
        read_grid();
        n_cmp += 3;
        if (got[15][15] !== 1'b0) begin n_bad++; $display("FAIL b3_six_nbrs: got %b want 0", got[15][15]); end
        if (hl_got[15][15] !== 1'b1) begin n_bad++; $display("FAIL b36_six_nbrs: got %b want 1", hl_got[15][15]); end
        if (hl_busy !== 1'b0) begin n_bad++; $display("FAIL highlife_idle_busy: got %b want 0", hl_busy); end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_protocol();
        test_reset_midrun();
        test_glider();
        test_rule();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/life_row_engine.md
# life_row_engine

Parametrised Game-of-Life generation engine holding a HEIGHT×WIDTH cell grid in internal registers. It advances the grid a requested number of generations, one full row per clock, under a configurable birth/survive rule. Host-side load and readback ports sit beside a start/busy/done handshake. It succeeds the fully-parallel single-step grid and trades per-cycle area for HEIGHT cycles per generation.

## Interface
- WIDTH, 64, cells per row (≥3)
- HEIGHT, 64, rows in grid (≥3)
- BIRTH_MASK, 9'b0_0000_1000, bit n set ⇒ dead cell with n live neighbours becomes alive (B3)
- SURVIVE_MASK, 9'b0_0000_1100, bit n set ⇒ live cell with n live neighbours stays alive (S23)
- GEN_W, 16, width of generation counters
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  request run; sampled only in IDLE
- num_gens  in  GEN_W  generations to run, captured with start
- busy  out  1  high while running
- done  out  1  one-cycle pulse at run completion
- gen_count  out  GEN_W  generations completed in current/last run
- wr_en  in  1  host row write; ignored while busy
- wr_row  in  $clog2(HEIGHT)  row index for write
- wr_data  in  WIDTH  row contents, bit x = column x
- rd_row  in  $clog2(HEIGHT)  row index for readback
- rd_data  out  WIDTH  registered contents of grid[rd_row]

## Operation
- Reset: grid all zero, FSM IDLE, busy=0, done=0, gen_count=0, rd_data=0, row pointer 0.
- FSM states IDLE → RUN → FIN → IDLE.
- IDLE: wr_en writes grid[wr_row]=wr_data. start=1 captures num_gens and clears gen_count. If num_gens=0, go to FIN; otherwise go to RUN with row pointer r=0.
- RUN: each cycle computes the next state of row r from rows r-1, r, r+1 and writes it in place at row r.
  - Row r-1 has already been overwritten. A prev_orig register holds the pre-update copy of row r-1.
  - A row0_orig register holds the original row 0 for wrap use at r=HEIGHT-1.
  - On r=HEIGHT-1 the generation ends: gen_count++, r←0, prev_orig/row0_orig reloaded for the next generation.
  - When gen_count reaches num_gens, go to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Rule: n = live neighbour count (0..8, 4-bit unsigned). next = cur ? SURVIVE_MASK[n] : BIRTH_MASK[n].
- Edges: cells outside the grid count as dead (default).
- Ignored inputs: start in RUN/FIN ignored; wr_en in RUN/FIN ignored (no write, no error).
- rd_data ← grid[rd_row] every cycle in all states. During RUN, rows <r hold generation g+1 and rows ≥r hold generation g.
- Reset mid-run: immediate abort, all state per reset, no done pulse.

## Timing
- start accepted at edge T ⇒ busy=1 from T+1.
- Row r of generation g (0-based) is written at edge T+1+g·HEIGHT+r.
- Last row written at edge T+num_gens·HEIGHT; done=1 and busy=0 in the following cycle.
- Total start-to-done = num_gens·HEIGHT+1 cycles.
- num_gens=0: done one cycle after start acceptance, grid untouched, gen_count=0.
- gen_count updates on the same edge as the last row of each generation.
- rd_data latency 1 cycle. A wr_en and a rd_row hitting the same row on the same edge return the old contents.
- A new start is accepted in the cycle after done.

## Configuration
- LIFE_TORUS_EN defined: toroidal wrap. Row -1 ≡ HEIGHT-1 (taken from grid, still original), row HEIGHT ≡ row0_orig, and column -1 ≡ WIDTH-1, column WIDTH ≡ 0.
- LIFE_TORUS_EN undefined: dead border. row0_orig register and wrap muxes are not built.

## Structure
- Package life_pkg:
  - nbr_cnt_t (logic [3:0])
  - default BIRTH/SURVIVE constants B3_MASK, S23_MASK
  - HighLife constant B36_MASK
  - fsm state enum state_t {IDLE, RUN, FIN}
  - function apply_rule(cur, n, birth, survive)
- Sub-module life_row_update: purely combinational, WIDTH-parameterised. Inputs above/cur/below rows plus wrap enable; output is the next row. Instantiated once.

## Test plan
- Blinker: load row 5 cols 4-6 set, num_gens=1 → after done col 5 rows 4-6 set, all else zero; num_gens=2 → original pattern; gen_count=2.
- Block still life: 2×2 at (10,10), num_gens=7 → grid unchanged; done exactly 7·HEIGHT+1 cycles after start.
- Edge behaviour: glider crossing the right edge, 4·WIDTH generations. LIFE_TORUS_EN defined → glider returns to origin shape, shifted (WIDTH,WIDTH) mod size; undefined → cells die/stabilise at the border, no wrap cells appear at col 0.
- num_gens=0 plus protocol: done 1 cycle after start, grid unchanged. start and wr_en asserted mid-run → no effect on run length or contents.
- Reset mid-run at generation 3 row 20 → busy=0, gen_count=0, no done pulse, grid reads all zero.
- Rule parameter: BIRTH_MASK=B36_MASK; dead cell with 6 live neighbours → alive after 1 generation (stays dead with default B3).
